arbiter_sync_rr: RTL and testbench
==================================

Name: arbiter_sync_rr

Overview:
- Round-robin memory arbiter between N requester ports and the single SDRAM controller request port, all on clkSYS.
- Alternative to the fixed-priority arbiter, for use when TFT, ADC capture and test clients must get bounded, fair bandwidth.
- Grants one requester at a time for up to BURST accepted words. It tags each forwarded request with the requester index, and routes returned read data back to the requester whose index matches the returned tag.

Parameters:
AN, 24, address width
DN, 16, data width
N, 4, number of requesters (2..8)
IDN, 2, width of the id tag (must satisfy 2**IDN >= N)
BURST, 8, maximum accepted requests per grant before rotation

Ports:
clkSYS  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  N  per-requester request
wr  in  N  per-requester write flag (1=write, 0=read)
addr  in  N*AN  per-requester address; slice i = addr[i*AN +: AN]
data  in  N*DN  per-requester write data; slice i = data[i*DN +: DN]
ack  out  N  per-requester accept strobe
valid  out  N  per-requester read-data-valid strobe
rdata  out  DN  read data, broadcast to all requesters
mem_req  out  1  request to memory controller
mem_wr  out  1  write flag to controller
mem_addr  out  AN  address to controller
mem_data  out  DN  write data to controller
mem_id  out  IDN  tag = granted requester index
mem_ack  in  1  controller accepts current request this cycle
mem_valid  in  1  controller read data valid
mem_rdata  in  DN  controller read data
mem_rid  in  IDN  tag of returned read data

Behaviour:
- Reset values: state=IDLE, gnt=0, last=N-1 (so requester 0 wins first), cnt=0. Outputs ack, valid, mem_req all 0; rdata=0.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first i with req[i]=1, searching cyclically from last+1.
  - Register gnt=i, set last=i, cnt=0, go to GRANT.
  - mem_req stays 0 in IDLE, so there is 1 cycle of arbitration latency.
- GRANT, combinational outputs:
  - mem_req = req[gnt]; mem_wr, mem_addr, mem_data come from slice gnt; mem_id = gnt.
  - ack[gnt] = mem_ack & req[gnt]; all other ack bits are 0.
- GRANT, counting and release:
  - Each cycle with mem_ack & req[gnt], cnt increments.
  - Release to IDLE on the cycle an ack makes cnt reach BURST.
  - Also release on any cycle where req[gnt]=0 (the requester has finished early).
  - A simultaneous ack and req drop is impossible, since ack requires req. An ack on the final word counts, then the block releases.
- Requester rule: a requester must hold req, wr, addr and data stable until it sees ack, and may change them on the cycle after.
- Rotation:
  - After a release, the next grant starts searching at last+1. A requester that still has req asserted must wait for all other pending requesters.
  - With a single active requester, it is regranted after a 1-cycle IDLE bubble.
- Read return path, registered with 1 cycle latency:
  - valid[k] <= mem_valid & (mem_rid==k); rdata <= mem_rdata when mem_valid.
  - If mem_rid >= N, the data is dropped and no valid is asserted.
  - The return path operates independently of grant state; data for a non-granted requester is still delivered.
- mem_ack arriving while mem_req=0 (IDLE, or req[gnt] low) is ignored; cnt is unchanged.
- Reset mid-burst: on the next edge state=IDLE and all strobes are 0. In-flight read returns arriving after reset are still routed by tag (registered path), but valid is forced to 0 during the reset cycle itself.
- Reset dominates all other events in the same cycle.

Test Plan:
1. Reset, then req=4'b0001 holding 8 reads (mem_ack every cycle) -> mem_req rises 1 cycle after req, mem_id=0, exactly 8 ack[0] pulses, then mem_req=0 for 1 cycle before regrant.
2. All four req held high, mem_ack always 1 -> grant order 0,1,2,3,0. Each grant gets 8 acks; mem_id follows that sequence.
3. req[2] asserted for 3 words then dropped, req[1] pending -> 3 ack[2] pulses, IDLE for 1 cycle, then gnt=3 if req[3] is set, else gnt=1 (the search starts at 3).
4. mem_ack held low for 5 cycles mid-burst -> mem_req stays high with mem_addr stable, cnt frozen, no ack pulses.
5. mem_valid=1 with mem_rid=2 and mem_rdata=16'hBEEF while gnt=0 -> next cycle valid=4'b0100 and rdata=16'hBEEF. With N=3 and mem_rid=3 -> valid=0.
6. reset asserted on the 4th word of a burst -> next cycle mem_req=0 and ack=0, last=N-1. After reset releases with req=4'b1111, gnt=0.

Source files
------------

// File: rtl/arbiter_sync_rr_if.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_sync_rr_if
//  Purpose  : Bundle of the requester-side and memory-side handshake signals
//             of the round-robin SDRAM arbiter.
//  Modports : slave  - arbiter view (requests/memory responses in,
//                      acks/read data/memory requests out)
//             master - environment view (requesters + memory controller)
//  Signals  : req/wr/addr/data   per-requester request bus (N slices)
//             ack/valid/rdata    per-requester accept / read return
//             mem_*              single port towards the SDRAM controller
//  Revision : 1.0 - initial release
// ============================================================================
interface arbiter_sync_rr_if #(
  parameter int AN  = 24,
  parameter int DN  = 16,
  parameter int N   = 4,
  parameter int IDN = 2
);
  // requester side
  logic [N-1:0]    req;
  logic [N-1:0]    wr;
  logic [N*AN-1:0] addr;
  logic [N*DN-1:0] data;
  logic [N-1:0]    ack;
  logic [N-1:0]    valid;
  logic [DN-1:0]   rdata;

  // memory controller side
  logic            mem_req;
  logic            mem_wr;
  logic [AN-1:0]   mem_addr;
  logic [DN-1:0]   mem_data;
  logic [IDN-1:0]  mem_id;
  logic            mem_ack;
  logic            mem_valid;
  logic [DN-1:0]   mem_rdata;
  logic [IDN-1:0]  mem_rid;

  modport slave (
    input  req, wr, addr, data, mem_ack, mem_valid, mem_rdata, mem_rid,
    output ack, valid, rdata, mem_req, mem_wr, mem_addr, mem_data, mem_id
  );

  modport master (
    output req, wr, addr, data, mem_ack, mem_valid, mem_rdata, mem_rid,
    input  ack, valid, rdata, mem_req, mem_wr, mem_addr, mem_data, mem_id
  );
endinterface
`default_nettype wire

// File: rtl/arbiter_sync_rr.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_sync_rr
//  Purpose  : Round-robin arbiter between N requesters and one SDRAM
//             controller port. A grant lasts up to BURST accepted words or
//             until the granted requester drops req. Forwarded requests are
//             tagged with the requester index; read data is routed back by
//             the returned tag through a 1-cycle registered path.
//  Ports    : clkSYS - system clock, rising edge
//             reset  - synchronous active-high reset
//             bus    - arbiter_sync_rr_if.slave (requester + memory signals)
//  Revision : 1.0 - initial release
// ============================================================================
module arbiter_sync_rr #(
  parameter int AN    = 24,
  parameter int DN    = 16,
  parameter int N     = 4,
  parameter int IDN   = 2,
  parameter int BURST = 8
) (
  input wire logic          clkSYS,
  input wire logic          reset,
  arbiter_sync_rr_if.slave  bus
);

  // Request vectors padded to the full tag range so that indexing by a
  // tag-width value never leaves the vector.
  localparam int NP = 1 << IDN;
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q;
  logic [IDN-1:0]  gnt_q;
  logic [IDN-1:0]  last_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    valid_q;
  logic [N-1:0]    valid_d;
  logic [DN-1:0]   rdata_q;

  logic [NP-1:0]   w_req_pad;
  logic [NP-1:0]   w_wr_pad;
  logic [NP-1:0]   w_ack_pad;
  logic            w_req_g;
  logic            w_active;
  logic            w_accept;
  logic [IDN-1:0]  w_pick;
  logic [IDN:0]    w_idx;

  assign w_req_pad = NP'(bus.req);
  assign w_wr_pad  = NP'(bus.wr);
  assign w_req_g   = w_req_pad[gnt_q];
  assign w_active  = (state_q == GRANT) && w_req_g;
  assign w_accept  = w_active && bus.mem_ack;

  // --------------------------------------------------------------------------
  // Cyclic search starting at last+1. Iterating from the farthest candidate
  // back to the nearest leaves the nearest requesting index in w_pick.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pick = last_q;
    w_idx  = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = {1'b0, last_q} + (IDN+1)'(k);
      if (w_idx >= (IDN+1)'(N)) begin
        w_idx = w_idx - (IDN+1)'(N);
      end
      if (w_req_pad[w_idx[IDN-1:0]]) begin
        w_pick = w_idx[IDN-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Forwarded request: combinational from the granted slice
  // --------------------------------------------------------------------------
  assign bus.mem_req  = w_active;
  assign bus.mem_wr   = w_wr_pad[gnt_q];
  assign bus.mem_addr = bus.addr[gnt_q*AN +: AN];
  assign bus.mem_data = bus.data[gnt_q*DN +: DN];
  assign bus.mem_id   = gnt_q;

  always_comb begin
    w_ack_pad = '0;
    if (w_accept) begin
      w_ack_pad[gnt_q] = 1'b1;
    end
  end

  assign bus.ack = w_ack_pad[N-1:0];

  // --------------------------------------------------------------------------
  // Grant state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clkSYS) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDN'(N - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            gnt_q   <= w_pick;
            last_q  <= w_pick;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!w_req_g) begin
            // requester finished early
            state_q <= IDLE;
          end else if (bus.mem_ack) begin
            if (cnt_q == CW'(BURST - 1)) begin
              cnt_q   <= CW'(BURST);
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read return path: independent of grant state. Tags with no matching
  // requester produce no valid strobe.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N; k++) begin : g_valid
    assign valid_d[k] = bus.mem_valid && (bus.mem_rid == IDN'(k));
  end

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      valid_q <= '0;
      rdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (bus.mem_valid) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.valid = valid_q;
  assign bus.rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_sync_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbiter_sync_rr
//  Purpose  : Directed self-checking bench for arbiter_sync_rr (N=4 main
//             instance plus an N=3 instance for out-of-range read tags).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arbiter_sync_rr;

  localparam int AN    = 24;
  localparam int DN    = 16;
  localparam int IDN   = 2;
  localparam int BURST = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [AN-1:0] a_tab [4];
  logic [DN-1:0] d_tab [4];

  always #5 clk = ~clk;

  arbiter_sync_rr_if #(.AN(AN), .DN(DN), .N(4), .IDN(IDN)) bus4 ();
  arbiter_sync_rr_if #(.AN(AN), .DN(DN), .N(3), .IDN(IDN)) bus3 ();

  arbiter_sync_rr #(.AN(AN), .DN(DN), .N(4), .IDN(IDN), .BURST(BURST)) dut (
    .clkSYS (clk),
    .reset  (rst),
    .bus    (bus4.slave)
  );

  arbiter_sync_rr #(.AN(AN), .DN(DN), .N(3), .IDN(IDN), .BURST(BURST)) dut3 (
    .clkSYS (clk),
    .reset  (rst),
    .bus    (bus3.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    a_tab[0] = 24'h000100; a_tab[1] = 24'h011100;
    a_tab[2] = 24'h022200; a_tab[3] = 24'h033300;
    d_tab[0] = 16'h1000;   d_tab[1] = 16'h1111;
    d_tab[2] = 16'h2222;   d_tab[3] = 16'h3333;

    bus4.req       = 4'b0000;
    bus4.wr        = 4'b0010;
    bus4.addr      = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
    bus4.data      = {d_tab[3], d_tab[2], d_tab[1], d_tab[0]};
    bus4.mem_ack   = 1'b0;
    bus4.mem_valid = 1'b0;
    bus4.mem_rdata = '0;
    bus4.mem_rid   = '0;
    bus3.req       = '0;
    bus3.wr        = '0;
    bus3.addr      = '0;
    bus3.data      = '0;
    bus3.mem_ack   = 1'b0;
    bus3.mem_valid = 1'b0;
    bus3.mem_rdata = '0;
    bus3.mem_rid   = '0;

    // reset state
    nxt(); nxt(); #1;
    chk("rst_mem_req", bus4.mem_req, 0);
    chk("rst_ack",     bus4.ack,     0);
    chk("rst_valid",   bus4.valid,   0);
    chk("rst_rdata",   bus4.rdata,   0);

    // single requester, full burst, bubble, regrant
    nxt(); rst = 1'b0; bus4.req = 4'b0001; bus4.mem_ack = 1'b1; #1;
    chk("t1_latency", bus4.mem_req, 0);
    for (int i = 0; i < BURST; i++) begin
      nxt(); #1;
      chk("t1_req",  bus4.mem_req,  1);
      chk("t1_id",   bus4.mem_id,   0);
      chk("t1_ack",  bus4.ack,      4'b0001);
      chk("t1_addr", bus4.mem_addr, a_tab[0]);
    end
    nxt(); #1;
    chk("t1_bubble",     bus4.mem_req, 0);
    chk("t1_bubble_ack", bus4.ack,     0);
    nxt(); #1;
    chk("t1_regrant",    bus4.mem_req, 1);
    chk("t1_regrant_id", bus4.mem_id,  0);
    nxt(); bus4.req = 4'b0000; #1;
    chk("t1_drop", bus4.mem_req, 0);

    // all four requesting: 0,1,2,3,0
    nxt(); rst = 1'b1; #1;
    nxt(); rst = 1'b0; bus4.req = 4'b1111; #1;
    chk("t2_idle", bus4.mem_req, 0);
    for (int g = 0; g < 5; g++) begin
      if (g > 0) begin
        nxt(); #1;
        chk("t2_bubble", bus4.mem_req, 0);
      end
      for (int i = 0; i < BURST; i++) begin
        nxt(); #1;
        chk("t2_id",   bus4.mem_id,   g % 4);
        chk("t2_ack",  bus4.ack,      1 << (g % 4));
        chk("t2_addr", bus4.mem_addr, a_tab[g % 4]);
      end
    end

    // early release by requester 2, search resumes at 3 -> requester 1
    nxt(); bus4.req = 4'b0100; #1;
    chk("t3_idle", bus4.mem_req, 0);
    nxt(); bus4.req = 4'b0110; #1;
    chk("t3_id2",  bus4.mem_id, 2);
    chk("t3_ack1", bus4.ack,    4'b0100);
    nxt(); #1;
    chk("t3_ack2", bus4.ack,    4'b0100);
    nxt(); #1;
    chk("t3_ack3", bus4.ack,    4'b0100);
    nxt(); bus4.req = 4'b0010; #1;
    chk("t3_drop_req", bus4.mem_req, 0);
    chk("t3_drop_ack", bus4.ack,     0);
    nxt(); #1;
    chk("t3_bubble",     bus4.mem_req, 0);
    chk("t3_bubble_ack", bus4.ack,     0);
    nxt(); #1;
    chk("t3_id1",   bus4.mem_id,   1);
    chk("t3_req",   bus4.mem_req,  1);
    chk("t3_ack",   bus4.ack,      4'b0010);
    chk("t3_wr",    bus4.mem_wr,   1);
    chk("t3_data",  bus4.mem_data, d_tab[1]);

    // stall: mem_ack low for 5 cycles, count frozen at 1
    for (int i = 0; i < 5; i++) begin
      nxt(); bus4.mem_ack = 1'b0; #1;
      chk("t4_req",  bus4.mem_req,  1);
      chk("t4_ack",  bus4.ack,      0);
      chk("t4_addr", bus4.mem_addr, a_tab[1]);
    end
    for (int i = 0; i < BURST - 1; i++) begin
      nxt(); bus4.mem_ack = 1'b1; #1;
      chk("t4_resume_ack", bus4.ack, 4'b0010);
    end
    nxt(); bus4.req = 4'b0000; #1;
    chk("t4_release", bus4.mem_req, 0);

    // read return routing by tag
    nxt();
    bus4.req = 4'b0001; bus4.mem_ack = 1'b0;
    bus4.mem_valid = 1'b1; bus4.mem_rid = 2'd2; bus4.mem_rdata = 16'hBEEF;
    bus3.mem_valid = 1'b1; bus3.mem_rid = 2'd3; bus3.mem_rdata = 16'hCAFE;
    nxt();
    bus4.mem_valid = 1'b0;
    bus3.mem_rid = 2'd0; bus3.mem_rdata = 16'h1234;
    #1;
    chk("t5_valid",   bus4.valid,   4'b0100);
    chk("t5_rdata",   bus4.rdata,   16'hBEEF);
    chk("t5_gnt0",    bus4.mem_id,  0);
    chk("t5_gnt_req", bus4.mem_req, 1);
    chk("t5_n3_rid3", bus3.valid,   3'b000);
    nxt(); bus3.mem_valid = 1'b0; #1;
    chk("t5_valid_off", bus4.valid, 0);
    chk("t5_rdata_hold", bus4.rdata, 16'hBEEF);
    chk("t5_n3_rid0",   bus3.valid, 3'b001);
    chk("t5_n3_rdata",  bus3.rdata, 16'h1234);

    // reset on the 4th word of a burst
    for (int w = 1; w <= 4; w++) begin
      nxt(); bus4.mem_ack = 1'b1;
      if (w == 4) begin
        rst = 1'b1;
        bus4.mem_valid = 1'b1; bus4.mem_rid = 2'd1; bus4.mem_rdata = 16'h7777;
      end
      #1;
      chk("t6_word_ack", bus4.ack, 4'b0001);
    end
    nxt(); rst = 1'b0; bus4.req = 4'b1111;
    bus4.mem_rid = 2'd3; bus4.mem_rdata = 16'h5555; #1;
    chk("t6_mem_req", bus4.mem_req, 0);
    chk("t6_ack",     bus4.ack,     0);
    chk("t6_valid",   bus4.valid,   0);
    chk("t6_rdata",   bus4.rdata,   0);
    nxt(); bus4.mem_valid = 1'b0; #1;
    chk("t6_gnt0",     bus4.mem_id,  0);
    chk("t6_req",      bus4.mem_req, 1);
    chk("t6_ret_valid", bus4.valid,  4'b1000);
    chk("t6_ret_rdata", bus4.rdata,  16'h5555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
